lsu: RTL

//  Load/store unit sitting directly downstream of the ALU in the multi-cycle core. It consumes the ALU's

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_if.sv | 23 ++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [STRB_W-1:0] STRB_B = 4'b0001;
    localparam logic [STRB_W-1:0] STRB_H = 4'b0011;
    localparam logic [STRB_W-1:0] STRB_W_ALL = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/lsu_if.sv
// Word-wide data-memory bus with req/ack handshake and byte strobes.
interface lsu_if;
    import lsu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/data replication, access checks and load extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [2:0]        funct3_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    input  logic [1:0]        rd_lane_i,
    input  logic [2:0]        rd_funct3_i,
    output logic [STRB_W-1:0] wstrb_c_o,
    output logic [XLEN-1:0]   wdata_c_o,
    output logic              misaligned_c_o,
    output logic              illegal_c_o,
    output logic [XLEN-1:0]   rdata_ext_c_o
);

    logic       mis;
    logic       ill;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Request-side decode from the live address/funct3
    always_comb begin
        wstrb_c_o = '0;
        wdata_c_o = wdata_i;
        mis       = 1'b0;
        ill       = 1'b0;
        case (funct3_i)
            F3_B: begin
                wstrb_c_o = STRB_B << addr_lo_i;
                wdata_c_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                wstrb_c_o = STRB_H << {addr_lo_i[1], 1'b0};
                wdata_c_o = {2{wdata_i[15:0]}};
                mis       = addr_lo_i[0];
            end
            F3_W: begin
                wstrb_c_o = STRB_W_ALL;
                mis       = |addr_lo_i;
            end
            F3_BU, F3_HU: begin
                ill = is_store_i;
                mis = (funct3_i == F3_HU) && addr_lo_i[0];
            end
            default: ill = 1'b1;
        endcase
        if (is_load_i && is_store_i) begin
            ill = 1'b1;
        end
        illegal_c_o    = ill;
        misaligned_c_o = mis && !ill;
    end

    // Response-side lane select using the latched address/funct3
    always_comb begin
        byte_sel = 8'(rdata_i >> {rd_lane_i, 3'b000});
        half_sel = rd_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (rd_funct3_i)
            F3_B:    rdata_ext_c_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_ext_c_o = {24'd0, byte_sel};
            F3_H:    rdata_ext_c_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_ext_c_o = {16'd0, half_sel};
            default: rdata_ext_c_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted start, with fault and timeout traps.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] address_i,
    input  logic [XLEN-1:0] rs2_val_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            misaligned_o,
    output logic            illegal_o,
    output logic            bus_err_o,
    lsu_if.master           mem
);

    localparam logic [CNT_W:0] TIMEOUT_LIM = TIMEOUT[CNT_W:0];

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              mem_req_q, mem_req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic              is_load_q, is_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              misaligned_q, misaligned_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic [STRB_W-1:0] wstrb_c;
    logic [XLEN-1:0]   wdata_c;
    logic              misaligned_c;
    logic              illegal_c;
    logic [XLEN-1:0]   rdata_ext_c;
    logic [CNT_W:0]    cnt_inc_c;
    logic              timeout_hit_c;

    lsu_align u_align (
        .addr_lo_i      (address_i[1:0]),
        .funct3_i       (funct3_i),
        .is_load_i      (is_load_i),
        .is_store_i     (is_store_i),
        .wdata_i        (rs2_val_i),
        .rdata_i        (mem.mem_rdata),
        .rd_lane_i      (lane_q),
        .rd_funct3_i    (funct3_q),
        .wstrb_c_o      (wstrb_c),
        .wdata_c_o      (wdata_c),
        .misaligned_c_o (misaligned_c),
        .illegal_c_o    (illegal_c),
        .rdata_ext_c_o  (rdata_ext_c)
    );

    // Expiry is judged on the count this wait cycle would reach
    assign cnt_inc_c     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_inc_c >= TIMEOUT_LIM);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        mem_req_d    = mem_req_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        is_load_d    = is_load_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (is_load_i || is_store_i)) begin
                    misaligned_d = misaligned_c;
                    illegal_d    = illegal_c;
                    bus_err_d    = 1'b0;
                    busy_d       = 1'b1;
                    funct3_d     = funct3_i;
                    lane_d       = address_i[1:0];
                    is_load_d    = is_load_i;
                    if (misaligned_c || illegal_c) begin
                        state_d = S_FAULT;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        cnt_d       = '0;
                        req_d.we    = is_store_i;
                        req_d.addr  = {address_i[XLEN-1:2], 2'b00};
                        req_d.wdata = wdata_c;
                        req_d.wstrb = is_store_i ? wstrb_c : '0;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (is_load_q) begin
                        load_data_d = rdata_ext_c;
                    end
                end else if (timeout_hit_c) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_inc_c[CNT_W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            mem_req_q    <= 1'b0;
            cnt_q        <= '0;
            funct3_q     <= '0;
            lane_q       <= '0;
            is_load_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            mem_req_q    <= mem_req_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            is_load_q    <= is_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = req_q.we;
    assign mem.mem_addr  = req_q.addr;
    assign mem.mem_wdata = req_q.wdata;
    assign mem.mem_wstrb = req_q.wstrb;

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign load_data_o   = load_data_q;
    assign misaligned_o  = misaligned_q;
    assign illegal_o     = illegal_q;
    assign bus_err_o     = bus_err_q;

endmodule
